// File: rtl/uart_programmer_if.sv
// Memory write port from the UART boot-loader to the CPU's instruction ROM / data memory.
// Latency: n/a (pure signal bundle).
// Backpressure: none; the master writes one word per strobe and the memory must accept it.
interface uart_programmer_if #(
  parameter int ADDR_W = 15
);
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;

  modport master (
    output upg_wen_o,
    output upg_adr_o,
    output upg_dat_o,
    output upg_done_o
  );

  modport slave (
    input upg_wen_o,
    input upg_adr_o,
    input upg_dat_o,
    input upg_done_o
  );
endinterface

// File: rtl/uart_programmer.sv
// UART boot-loader: receives {target, N, 4N data bytes} after start_pg and writes little-endian words.
// Latency: write strobe one cycle after the 4th byte's valid pulse; ack byte starts one cycle after ACK/ERR entry.
// Backpressure: none; the UART byte rate bounds the write rate. Optional trailing checksum byte: UPG_CHECKSUM_EN.
module uart_programmer #(
  parameter int BAUD_DIV = 868,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_pg,
  input  logic                rx,
  output logic                tx,
  uart_programmer_if.master   upg
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0]   MAX_N   = 32'd1 << (ADDR_W - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_TGT  = 4'd1;
  localparam logic [3:0] S_LEN0 = 4'd2;
  localparam logic [3:0] S_LEN1 = 4'd3;
  localparam logic [3:0] S_DATA = 4'd4;
  localparam logic [3:0] S_ACK  = 4'd5;
  localparam logic [3:0] S_DONE = 4'd6;
  localparam logic [3:0] S_ERR  = 4'd7;
`ifdef UPG_CHECKSUM_EN
  localparam logic [3:0] S_CSUM = 4'd8;
`endif

  logic            rx_s1, rx_s2, rx_s3;
  logic            start_q, start_rise;
  logic [1:0]      rx_st;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            byte_vld, frm_err;

  logic            tx_busy, tx_go;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_sh;
  logic [7:0]      tx_byte;

  logic [3:0]        state;
  logic              target;
  logic [15:0]       len, wdone, n_hdr;
  logic              n_ok;
  logic [ADDR_W-2:0] idx;
  logic [1:0]        bcnt;
  logic [23:0]       wsh;
  logic              tx_launched;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign start_rise = start_pg & ~start_q;
  assign n_hdr      = {rx_sh, len[7:0]};
  assign n_ok       = (n_hdr != 16'd0) && ({16'd0, n_hdr} <= MAX_N);
  assign tx_byte    = (state == S_ACK) ? 8'h4B : 8'h45;
  assign tx_go      = ((state == S_ACK) || (state == S_ERR)) && !tx_launched && !tx_busy && !start_rise;

  // Synchronize rx (third flop gives the previous value for edge detect) and register start_pg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      start_q <= start_pg;
    end
  end

  // 8N1 receiver: mid-bit sampling, one-cycle byte_vld / frm_err pulse after the stop-bit sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      byte_vld <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      frm_err  <= 1'b0;
      case (rx_st)
        R_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_st  <= R_START;
            rx_cnt <= '0;
          end
        end
        R_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt <= '0;
            rx_st  <= R_IDLE;
            if (rx_s2) byte_vld <= 1'b1;
            else       frm_err  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // 8N1 transmitter: runs independently of the loader so an in-flight byte always completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (tx_go) begin
      tx      <= 1'b0;
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= {1'b1, tx_byte};
    end else if (tx_busy) begin
      if (tx_cnt == FULL_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // Loader FSM: parses header, assembles words, issues writes and sequences the ack/error byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      target         <= 1'b0;
      len            <= '0;
      wdone          <= '0;
      idx            <= '0;
      bcnt           <= '0;
      wsh            <= '0;
      tx_launched    <= 1'b0;
      upg.upg_wen_o  <= 1'b0;
      upg.upg_adr_o  <= '0;
      upg.upg_dat_o  <= '0;
      upg.upg_done_o <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      upg.upg_wen_o <= 1'b0;
      if (start_rise) begin
        // Arm or restart: any partial word is dropped.
        state          <= S_TGT;
        upg.upg_done_o <= 1'b0;
        idx            <= '0;
        wdone          <= '0;
        bcnt           <= '0;
        tx_launched    <= 1'b0;
`ifdef UPG_CHECKSUM_EN
        csum           <= '0;
`endif
      end else begin
        case (state)
          S_TGT: begin
            if (frm_err) state <= S_ERR;
            else if (byte_vld) begin
              target <= rx_sh[0];
              state  <= (rx_sh[7:1] == 7'd0) ? S_LEN0 : S_ERR;
            end
          end
          S_LEN0: begin
            if (frm_err) state <= S_ERR;
            else if (byte_vld) begin
              len[7:0] <= rx_sh;
              state    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (frm_err) state <= S_ERR;
            else if (byte_vld) begin
              len   <= n_hdr;
              state <= n_ok ? S_DATA : S_ERR;
            end
          end
          S_DATA: begin
            if (frm_err) state <= S_ERR;
            else if (byte_vld) begin
              wsh  <= {rx_sh, wsh[23:8]};
              bcnt <= bcnt + 2'd1;
`ifdef UPG_CHECKSUM_EN
              csum <= csum + rx_sh;
`endif
              if (bcnt == 2'd3) begin
                upg.upg_wen_o <= 1'b1;
                upg.upg_adr_o <= {target, idx};
                upg.upg_dat_o <= {rx_sh, wsh};
                idx           <= idx + (ADDR_W-1)'(1);
                wdone         <= wdone + 16'd1;
                if (wdone + 16'd1 == len) begin
`ifdef UPG_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state <= S_ACK;
`endif
                end
              end
            end
          end
`ifdef UPG_CHECKSUM_EN
          S_CSUM: begin
            if (frm_err) state <= S_ERR;
            else if (byte_vld) state <= (rx_sh == csum) ? S_ACK : S_ERR;
          end
`endif
          S_ACK: begin
            if (tx_go) tx_launched <= 1'b1;
            else if (tx_launched && !tx_busy) begin
              tx_launched    <= 1'b0;
              upg.upg_done_o <= 1'b1;
              state          <= S_DONE;
            end
          end
          S_ERR: begin
            if (tx_go) tx_launched <= 1'b1;
            else if (tx_launched && !tx_busy) begin
              tx_launched    <= 1'b0;
              upg.upg_done_o <= 1'b0;
              state          <= S_IDLE;
            end
          end
          S_IDLE, S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_programmer.sv
// Bench for uart_programmer: table-driven header/load vectors, hand-written restart/reset/checksum
// sequences, and randomized loads checked against a byte-stream reference model.
// Build with +define+UPG_CHECKSUM_EN to exercise the checksum variant.
module tb_uart_programmer;
  localparam int BD = 16;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_pg = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_programmer_if #(.ADDR_W(AW)) upg_bus ();

  uart_programmer #(.BAUD_DIV(BD), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_pg (start_pg),
    .rx       (rx),
    .tx       (tx),
    .upg      (upg_bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]      tx_q[$];
  logic [AW+31:0]  wr_q[$];
  logic [AW+31:0]  exp_q[$];
  logic [7:0]      stim_q[$];
  logic [7:0]      stim_sum;

  typedef struct {
    logic [7:0]  tgt;
    int          n;
    int          nw;
    logic [31:0] w0;
    int          ferr;
    logic [7:0]  exp_ack;
    int          exp_nw;
    bit          exp_done;
  } vec_t;

  vec_t vecs[7];

  // Write-port monitor: one record per cycle the strobe is seen high.
  always @(negedge clk) begin
    if (rst && upg_bus.upg_wen_o) wr_q.push_back({upg_bus.upg_adr_o, upg_bus.upg_dat_o});
  end

  // tx line decoder.
  initial begin : tx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (rst && !tx) begin
        repeat (BD/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx;
        end
        repeat (BD) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk);
    start_pg = 1'b1;
    repeat (2) @(negedge clk);
    start_pg = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic build(input logic [7:0] tgt, input int n, input int nw, input logic [31:0] w0);
    logic [31:0] w;
    stim_q.delete();
    stim_sum = 8'h00;
    stim_q.push_back(tgt);
    stim_q.push_back(8'(n));
    stim_q.push_back(8'(n >> 8));
    for (int k = 0; k < nw; k++) begin
      w = w0 + 32'(k);
      for (int j = 0; j < 4; j++) begin
        stim_q.push_back(w[8*j +: 8]);
        stim_sum = stim_sum + w[8*j +: 8];
      end
    end
  endtask

  // Sends stim_q; the byte at index ferr carries a low stop bit and ends the stream.
  task automatic run_stream(input int ferr);
    wr_q.delete();
    tx_q.delete();
    arm();
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], i == ferr);
      if (i == ferr) break;
    end
  endtask

  task automatic check_outcome(input string nm, input logic [7:0] exp_ack, input bit exp_done);
    bit got;
    logic [7:0] b;
    got = 1'b0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (tx_q.size() > 0) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s ack: no tx byte within budget, required %h", nm, exp_ack);
    end else begin
      b = tx_q.pop_front();
      chk({nm, " ack"}, 64'(b), 64'(exp_ack));
    end
    repeat (BD + 4) @(negedge clk);
    chk({nm, " done"}, 64'(upg_bus.upg_done_o), 64'(exp_done));
    chk({nm, " nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
      chk($sformatf("%s write%0d", nm, k), 64'(wr_q[k]), 64'(exp_q[k]));
    chk({nm, " extra_tx"}, 64'(tx_q.size()), 64'd0);
    repeat (2*BD) @(negedge clk);
  endtask

  // Reference: parse the byte stream by the protocol rules and list the writes/ack it should produce.
  task automatic model(input int ferr, output logic [7:0] ack, output bit done);
    int n;
    int p;
    logic [31:0] w;
    logic [7:0] sum;
    logic [AW-1:0] a;
    exp_q.delete();
    ack = 8'h45;
    done = 1'b0;
    sum = 8'h00;
    w = '0;
    if (ferr == 0 || stim_q[0] > 8'h01) return;
    if (ferr == 1 || ferr == 2) return;
    n = int'({stim_q[2], stim_q[1]});
    if (n == 0 || n > (1 << (AW-1))) return;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        p = 3 + 4*k + j;
        if (ferr == p) return;
        w[8*j +: 8] = stim_q[p];
        sum = sum + stim_q[p];
      end
      a = AW'(k);
      a[AW-1] = stim_q[0][0];
      exp_q.push_back({a, w});
    end
`ifdef UPG_CHECKSUM_EN
    if (ferr == 3 + 4*n || stim_q[3 + 4*n] != sum) return;
`endif
    ack = 8'h4B;
    done = 1'b1;
  endtask

  initial begin
    logic [7:0] m_ack;
    bit m_done;
    logic [AW-1:0] a;
    logic [7:0] tgt;
    int n;
    int ferr;

    vecs[0] = '{8'h00, 1,     1, 32'h12345678, -1, 8'h4B, 1, 1'b1};
    vecs[1] = '{8'h01, 3,     3, 32'h00000001, -1, 8'h4B, 3, 1'b1};
    vecs[2] = '{8'h07, 1,     0, 32'h0,        -1, 8'h45, 0, 1'b0};
    vecs[3] = '{8'h00, 0,     0, 32'h0,        -1, 8'h45, 0, 1'b0};
    vecs[4] = '{8'h00, 1,     1, 32'hA1B2C3D4,  4, 8'h45, 0, 1'b0};
    vecs[5] = '{8'h00, 16385, 0, 32'h0,        -1, 8'h45, 0, 1'b0};
    vecs[6] = '{8'h01, 2,     1, 32'h55AA55AA,  0, 8'h45, 0, 1'b0};

    repeat (5) @(negedge clk);
    chk("rst tx",   64'(tx), 64'd1);
    chk("rst wen",  64'(upg_bus.upg_wen_o), 64'd0);
    chk("rst adr",  64'(upg_bus.upg_adr_o), 64'd0);
    chk("rst dat",  64'(upg_bus.upg_dat_o), 64'd0);
    chk("rst done", 64'(upg_bus.upg_done_o), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      build(vecs[v].tgt, vecs[v].n, vecs[v].nw, vecs[v].w0);
`ifdef UPG_CHECKSUM_EN
      if (vecs[v].exp_ack == 8'h4B) stim_q.push_back(stim_sum);
`endif
      exp_q.delete();
      for (int k = 0; k < vecs[v].exp_nw; k++) begin
        a = AW'(k);
        a[AW-1] = vecs[v].tgt[0];
        exp_q.push_back({a, vecs[v].w0 + 32'(k)});
      end
      run_stream(vecs[v].ferr);
      check_outcome($sformatf("vec%0d", v), vecs[v].exp_ack, vecs[v].exp_done);
    end

    // Restart after two data bytes: only the second load's word may be written.
    build(8'h00, 1, 1, 32'h0);
    stim_q = stim_q[0:4];
    run_stream(-1);
    chk("restart no_partial_write", 64'(wr_q.size()), 64'd0);
    build(8'h00, 1, 1, 32'hCAFEF00D);
`ifdef UPG_CHECKSUM_EN
    stim_q.push_back(stim_sum);
`endif
    exp_q.delete();
    exp_q.push_back({AW'(0), 32'hCAFEF00D});
    wr_q.delete();
    tx_q.delete();
    arm();
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    check_outcome("restart", 8'h4B, 1'b1);

`ifdef UPG_CHECKSUM_EN
    build(8'h00, 1, 1, 32'h01010101);
    stim_q.push_back(8'h04);
    exp_q.delete();
    exp_q.push_back({AW'(0), 32'h01010101});
    run_stream(-1);
    check_outcome("csum_good", 8'h4B, 1'b1);
    stim_q[7] = 8'h05;
    run_stream(-1);
    check_outcome("csum_bad", 8'h45, 1'b0);
`endif

    // Reset in the middle of a load after a successful one.
    build(8'h00, 2, 1, 32'h44332211);
    stim_q = stim_q[0:4];
    run_stream(-1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst tx",   64'(tx), 64'd1);
    chk("midrst wen",  64'(upg_bus.upg_wen_o), 64'd0);
    chk("midrst adr",  64'(upg_bus.upg_adr_o), 64'd0);
    chk("midrst dat",  64'(upg_bus.upg_dat_o), 64'd0);
    chk("midrst done", 64'(upg_bus.upg_done_o), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      tgt = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      stim_q.delete();
      stim_q.push_back(tgt);
      stim_q.push_back(8'(n));
      stim_q.push_back(8'h00);
      stim_sum = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        stim_q.push_back(8'($urandom_range(0, 255)));
        stim_sum = stim_sum + stim_q[3+i];
      end
`ifdef UPG_CHECKSUM_EN
      stim_q.push_back(stim_sum + 8'($urandom_range(0, 1)));
`endif
      ferr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, stim_q.size() - 1) : -1;
      model(ferr, m_ack, m_done);
      run_stream(ferr);
      check_outcome($sformatf("rand%0d", r), m_ack, m_done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
